// File: rtl/multdiv_ctrl_pkg.sv
// Shared encodings for the multiply/divide sequencer: opcode fields,
// exception codes, the rstatus index and the FSM state type.
package multdiv_ctrl_pkg;

    localparam logic [4:0]  OPC_RTYPE       = 5'd0;
    localparam logic [4:0]  ALU_MUL         = 5'd6;
    localparam logic [4:0]  ALU_DIV         = 5'd7;

    localparam int unsigned TIMEOUT_DEF     = 40;
    localparam logic [4:0]  RSTATUS_REG_DEF = 5'd30;
    localparam logic [31:0] EXC_MUL_DEF     = 32'd4;
    localparam logic [31:0] EXC_DIV_DEF     = 32'd5;
    localparam logic [31:0] EXC_TMO_DEF     = 32'd6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } md_state_e;

    function automatic logic is_zero32(input logic [31:0] v);
        return (v == 32'd0);
    endfunction

endpackage

// File: rtl/multdiv_ctrl_md_decode.sv
// Combinational decode of the D/X instruction into mul/div detect, kind and rd.
// Shared with the hazard logic so both agree on what counts as a mul/div.
module md_decode
    import multdiv_ctrl_pkg::*;
(
    input  logic [31:0] ir,
    output logic        is_md,
    output logic        is_div,
    output logic [4:0]  rd
);

    logic [4:0] opc_s;
    logic [4:0] fn_s;
    logic       ir_unused_s;

    assign opc_s       = ir[31:27];
    assign fn_s        = ir[6:2];
    assign ir_unused_s = ^{ir[21:7], ir[1:0]};

    assign is_md  = (opc_s == OPC_RTYPE) && ((fn_s == ALU_MUL) || (fn_s == ALU_DIV));
    assign is_div = (fn_s == ALU_DIV);
    assign rd     = ir[26:22];

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencer for the multi-cycle mul/div unit: issues the start pulse, stalls
// the pipeline until a result (or exception/timeout) is ready, then writes back.
module multdiv_ctrl
    import multdiv_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT     = TIMEOUT_DEF,
    parameter logic [4:0]  RSTATUS_REG = RSTATUS_REG_DEF,
    parameter logic [31:0] EXC_MUL     = EXC_MUL_DEF,
    parameter logic [31:0] EXC_DIV     = EXC_DIV_DEF,
    parameter logic [31:0] EXC_TMO     = EXC_TMO_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] DXIR,
    input  logic [31:0] dx_opA,
    input  logic [31:0] dx_opB,
    input  logic        md_resultRDY,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        wb_grant,
    output logic        md_ctrl_MULT,
    output logic        md_ctrl_DIV,
    output logic [31:0] md_opA,
    output logic [31:0] md_opB,
    output logic        stall,
    output logic        xm_kill,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    md_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [4:0]  rd_q, rd_d;
    logic        kind_div_q, kind_div_d;
    logic        mult_q, mult_d;
    logic        div_q, div_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;

    logic        dec_is_md_s;
    logic        dec_is_div_s;
    logic [4:0]  dec_rd_s;
    logic        div_by_zero_s;
    logic        timeout_hit_s;

    md_decode u_md_decode (
        .ir     (DXIR),
        .is_md  (dec_is_md_s),
        .is_div (dec_is_div_s),
        .rd     (dec_rd_s)
    );

    assign div_by_zero_s = dec_is_div_s && is_zero32(dx_opB);
    assign timeout_hit_s = (cnt_q == CNT_W'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (dec_is_md_s) begin
                    state_d = div_by_zero_s ? ST_DONE : ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: state_d = ST_BUSY;
            ST_BUSY: begin
                if (md_resultRDY || timeout_hit_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (wb_grant) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand latches, counter and next values of the registered outputs.
    always_comb begin
        opa_d      = opa_q;
        opb_d      = opb_q;
        rd_d       = rd_q;
        kind_div_d = kind_div_q;
        cnt_d      = cnt_q;
        mult_d     = 1'b0;
        div_d      = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        wb_valid_d = (state_d == ST_DONE);
        case (state_q)
            ST_IDLE: begin
                if (dec_is_md_s) begin
                    opa_d      = dx_opA;
                    opb_d      = dx_opB;
                    rd_d       = dec_rd_s;
                    kind_div_d = dec_is_div_s;
                    if (div_by_zero_s) begin
                        wb_rd_d   = RSTATUS_REG;
                        wb_data_d = EXC_DIV;
                    end else begin
                        mult_d = !dec_is_div_s;
                        div_d  = dec_is_div_s;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_START: cnt_d = '0;
            ST_BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                // The result wins over a timeout landing in the same cycle.
                if (md_resultRDY) begin
                    if (md_exception) begin
                        wb_rd_d   = RSTATUS_REG;
                        wb_data_d = kind_div_q ? EXC_DIV : EXC_MUL;
                    end else begin
                        wb_rd_d   = rd_q;
                        wb_data_d = md_result;
                    end
                end else if (timeout_hit_s) begin
                    wb_rd_d   = RSTATUS_REG;
                    wb_data_d = EXC_TMO;
                end else begin
                    wb_data_d = wb_data_q;
                end
            end
            ST_DONE: cnt_d = cnt_q;
            default: cnt_d = '0;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            opa_q      <= 32'd0;
            opb_q      <= 32'd0;
            rd_q       <= 5'd0;
            kind_div_q <= 1'b0;
            mult_q     <= 1'b0;
            div_q      <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= 32'd0;
        end else begin
            cnt_q      <= cnt_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            rd_q       <= rd_d;
            kind_div_q <= kind_div_d;
            mult_q     <= mult_d;
            div_q      <= div_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
        end
    end

    // Pipeline control: stall and kill follow the state and this cycle's inputs.
    always_comb begin
        stall   = 1'b0;
        xm_kill = 1'b0;
        case (state_q)
            ST_IDLE:  stall = dec_is_md_s;
            ST_START: stall = 1'b1;
            ST_BUSY:  stall = 1'b1;
            ST_DONE: begin
                stall   = !wb_grant;
                xm_kill = wb_grant;
            end
            default: begin
                stall   = 1'b0;
                xm_kill = 1'b0;
            end
        endcase
    end

    assign md_ctrl_MULT = mult_q;
    assign md_ctrl_DIV  = div_q;
    assign md_opA       = opa_q;
    assign md_opB       = opb_q;
    assign wb_valid     = wb_valid_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed self-checking bench for multdiv_ctrl: normal ops, exceptions,
// divide-by-zero, timeout, withheld grant, back-to-back issue and reset.
module tb_multdiv_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] DXIR;
    logic [31:0] dx_opA;
    logic [31:0] dx_opB;
    logic        md_resultRDY;
    logic [31:0] md_result;
    logic        md_exception;
    logic        wb_grant;
    logic        md_ctrl_MULT;
    logic        md_ctrl_DIV;
    logic [31:0] md_opA;
    logic [31:0] md_opB;
    logic        stall;
    logic        xm_kill;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int n_tests = 0;
    int n_fail  = 0;
    int mult_cnt = 0;
    int div_cnt  = 0;

    multdiv_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .DXIR         (DXIR),
        .dx_opA       (dx_opA),
        .dx_opB       (dx_opB),
        .md_resultRDY (md_resultRDY),
        .md_result    (md_result),
        .md_exception (md_exception),
        .wb_grant     (wb_grant),
        .md_ctrl_MULT (md_ctrl_MULT),
        .md_ctrl_DIV  (md_ctrl_DIV),
        .md_opA       (md_opA),
        .md_opB       (md_opB),
        .stall        (stall),
        .xm_kill      (xm_kill),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data)
    );

    always #5 clock = ~clock;

    // Count start pulses; each pulse is high for one full cycle.
    always @(negedge clock) begin
        if (md_ctrl_MULT === 1'b1) mult_cnt++;
        if (md_ctrl_DIV === 1'b1)  div_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    function automatic logic [31:0] mk_ir(input logic [4:0] opc, input logic [4:0] rd,
                                          input logic [4:0] fn);
        return {opc, rd, 15'd0, fn, 2'b00};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // One mul/div from detect through grant; rdy_at is the BUSY cycle (1-based)
    // carrying md_resultRDY, or -1 for never. Returns just after granting.
    task automatic run_op(input string tag, input logic [31:0] ir, input logic [31:0] a,
                          input logic [31:0] b, input int rdy_at, input logic exc,
                          input logic [31:0] res, input int hold, input logic [4:0] exp_rd,
                          input logic [31:0] exp_data, input int exp_lat,
                          input int exp_mult, input int exp_div);
        int k;
        int m0;
        int d0;
        @(negedge clock);
        check_eq({tag, ":wbv_before"}, 32'(wb_valid), 32'd0);
        m0 = mult_cnt;
        d0 = div_cnt;
        DXIR = ir;
        dx_opA = a;
        dx_opB = b;
        md_resultRDY = 1'b0;
        md_exception = 1'b0;
        wb_grant = 1'b0;
        #1;
        check_eq({tag, ":stall_detect"}, 32'(stall), 32'd1);
        check_eq({tag, ":kill_detect"}, 32'(xm_kill), 32'd0);
        k = 0;
        while (wb_valid !== 1'b1 && k < 80) begin
            @(negedge clock);
            k++;
            md_resultRDY = 1'b0;
            md_exception = 1'b0;
            if (wb_valid !== 1'b1) begin
                check_eq({tag, ":stall_wait"}, 32'(stall), 32'd1);
                if (k == 1) begin
                    check_eq({tag, ":opA"}, md_opA, a);
                    check_eq({tag, ":opB"}, md_opB, b);
                end
                if (k == rdy_at + 1) begin
                    md_resultRDY = 1'b1;
                    md_result = res;
                    md_exception = exc;
                end
            end
        end
        check_eq({tag, ":latency"}, 32'(k), 32'(exp_lat));
        check_eq({tag, ":wb_valid"}, 32'(wb_valid), 32'd1);
        check_eq({tag, ":wb_rd"}, 32'(wb_rd), 32'(exp_rd));
        check_eq({tag, ":wb_data"}, wb_data, exp_data);
        repeat (hold) begin
            check_eq({tag, ":stall_hold"}, 32'(stall), 32'd1);
            check_eq({tag, ":kill_hold"}, 32'(xm_kill), 32'd0);
            @(negedge clock);
            check_eq({tag, ":wbv_hold"}, 32'(wb_valid), 32'd1);
            check_eq({tag, ":rd_hold"}, 32'(wb_rd), 32'(exp_rd));
            check_eq({tag, ":data_hold"}, wb_data, exp_data);
        end
        wb_grant = 1'b1;
        #1;
        check_eq({tag, ":stall_grant"}, 32'(stall), 32'd0);
        check_eq({tag, ":kill_grant"}, 32'(xm_kill), 32'd1);
        check_eq({tag, ":mult_pulses"}, 32'(mult_cnt - m0), 32'(exp_mult));
        check_eq({tag, ":div_pulses"}, 32'(div_cnt - d0), 32'(exp_div));
    endtask

    task automatic idle_nop(input string tag);
        @(negedge clock);
        DXIR = 32'd0;
        wb_grant = 1'b0;
        md_resultRDY = 1'b0;
        #1;
        check_eq({tag, ":stall_idle"}, 32'(stall), 32'd0);
        check_eq({tag, ":kill_idle"}, 32'(xm_kill), 32'd0);
        check_eq({tag, ":wbv_idle"}, 32'(wb_valid), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, ":mult"}, 32'(md_ctrl_MULT), 32'd0);
        check_eq({tag, ":div"}, 32'(md_ctrl_DIV), 32'd0);
        check_eq({tag, ":opA"}, md_opA, 32'd0);
        check_eq({tag, ":opB"}, md_opB, 32'd0);
        check_eq({tag, ":stall"}, 32'(stall), 32'd0);
        check_eq({tag, ":kill"}, 32'(xm_kill), 32'd0);
        check_eq({tag, ":wbv"}, 32'(wb_valid), 32'd0);
        check_eq({tag, ":wb_rd"}, 32'(wb_rd), 32'd0);
        check_eq({tag, ":wb_data"}, wb_data, 32'd0);
    endtask

    initial begin
        int m0;
        reset = 1'b0;
        DXIR = 32'd0;
        dx_opA = 32'd0;
        dx_opB = 32'd0;
        md_resultRDY = 1'b0;
        md_result = 32'd0;
        md_exception = 1'b0;
        wb_grant = 1'b0;
        #1;
        check_all_zero("reset");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        run_op("mul7x6", mk_ir(5'd0, 5'd3, 5'd6), 32'd7, 32'd6, 5, 1'b0, 32'd42, 0,
               5'd3, 32'd42, 7, 1, 0);
        idle_nop("after_mul");
        run_op("divzero", mk_ir(5'd0, 5'd8, 5'd7), 32'd9, 32'd0, -1, 1'b0, 32'd0, 0,
               5'd30, 32'd5, 1, 0, 0);
        idle_nop("after_div0");
        run_op("mul_exc", mk_ir(5'd0, 5'd5, 5'd6), 32'd3, 32'd4, 2, 1'b1, 32'd12, 0,
               5'd30, 32'd4, 4, 1, 0);
        run_op("div_exc", mk_ir(5'd0, 5'd6, 5'd7), 32'd10, 32'd3, 3, 1'b1, 32'd3, 0,
               5'd30, 32'd5, 5, 0, 1);
        idle_nop("after_exc");
        run_op("div_min", mk_ir(5'd0, 5'd9, 5'd7), 32'd100, 32'd7, 1, 1'b0, 32'd14, 0,
               5'd9, 32'd14, 3, 0, 1);
        run_op("mul_rd0", mk_ir(5'd0, 5'd0, 5'd6), 32'd5, 32'd1, 2, 1'b0, 32'd5, 0,
               5'd0, 32'd5, 4, 1, 0);
        idle_nop("after_rd0");
        run_op("timeout", mk_ir(5'd0, 5'd7, 5'd6), 32'd1, 32'd1, -1, 1'b0, 32'd0, 0,
               5'd30, 32'd6, 42, 1, 0);
        idle_nop("after_tmo");
        run_op("hold3", mk_ir(5'd0, 5'd10, 5'd6), 32'd2, 32'd3, 1, 1'b0, 32'd6, 3,
               5'd10, 32'd6, 3, 1, 0);
        run_op("b2b", mk_ir(5'd0, 5'd11, 5'd6), 32'd4, 32'd5, 2, 1'b0, 32'd20, 0,
               5'd11, 32'd20, 4, 1, 0);
        idle_nop("after_b2b");

        // Instructions that must not be treated as mul/div.
        m0 = mult_cnt;
        @(negedge clock);
        DXIR = mk_ir(5'd0, 5'd3, 5'd5);
        #1;
        check_eq("nonmd_rtype:stall", 32'(stall), 32'd0);
        @(negedge clock);
        DXIR = mk_ir(5'd1, 5'd3, 5'd6);
        #1;
        check_eq("nonmd_opc:stall", 32'(stall), 32'd0);
        @(negedge clock);
        DXIR = 32'd0;
        check_eq("nonmd:pulses", 32'(mult_cnt - m0 + div_cnt), 32'(div_cnt));
        check_eq("nonmd:wbv", 32'(wb_valid), 32'd0);

        // Reset in BUSY, then a late result after release must be ignored.
        @(negedge clock);
        DXIR = mk_ir(5'd0, 5'd4, 5'd6);
        dx_opA = 32'd2;
        dx_opB = 32'd3;
        repeat (4) @(negedge clock);
        check_eq("rst_busy:stall_pre", 32'(stall), 32'd1);
        reset = 1'b0;
        DXIR = 32'd0;
        #1;
        check_all_zero("rst_busy");
        @(negedge clock);
        reset = 1'b1;
        m0 = mult_cnt;
        md_resultRDY = 1'b1;
        md_result = 32'd99;
        @(negedge clock);
        md_resultRDY = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check_eq("rst_late:wbv", 32'(wb_valid), 32'd0);
            check_eq("rst_late:stall", 32'(stall), 32'd0);
            check_eq("rst_late:wb_data", wb_data, 32'd0);
        end
        check_eq("rst_late:pulses", 32'(mult_cnt - m0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
Sequencer for the multi-cycle multiply/divide unit that sits beside the single-cycle ALU in the execute stage.
- Detects R-type mul/div in the D/X latch, captures operands and destination, and pulses the unit's start controls.
- Holds the pipeline stalled until the result returns, then presents a writeback request and kills the instruction's slot into X/M.
- Converts unit exceptions, divide-by-zero and timeout into rstatus writes.

Parameters:
TIMEOUT, 40, max cycles in BUSY before the operation is abandoned
RSTATUS_REG, 30, destination register for exception codes
EXC_MUL, 4, rstatus code for multiply exception
EXC_DIV, 5, rstatus code for divide exception, including divide-by-zero
EXC_TMO, 6, rstatus code for timeout

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
DXIR  in  32  instruction in D/X latch
dx_opA  in  32  bypassed operand A
dx_opB  in  32  bypassed operand B
md_resultRDY  in  1  unit result valid
md_result  in  32  unit result
md_exception  in  1  unit exception, qualified by md_resultRDY
wb_grant  in  1  writeback port granted to this block this cycle
md_ctrl_MULT  out  1  one-cycle start pulse, multiply
md_ctrl_DIV  out  1  one-cycle start pulse, divide
md_opA  out  32  latched operand A
md_opB  out  32  latched operand B
stall  out  1  freeze PC, F/D and D/X
xm_kill  out  1  insert nop into X/M instead of DXIR
wb_valid  out  1  writeback request
wb_rd  out  5  writeback register
wb_data  out  32  writeback value

Behaviour:
- Decode: is_md = (DXIR[31:27]==0) && (DXIR[6:2]==6 || DXIR[6:2]==7); is_div = DXIR[6:2]==7; rd = DXIR[26:22].
- Reset (asynchronous, reset low): state=IDLE, counter=0, all latches 0, all outputs 0. Reset mid-operation abandons the operation; late md_resultRDY after reset is ignored because state is IDLE.
- States are IDLE, START, BUSY, DONE.
- IDLE:
  - stall = is_md (combinational).
  - On is_md: latch opA, opB, rd and kind.
  - If is_div and dx_opB==0: go to DONE with wb_rd=RSTATUS_REG and wb_data=EXC_DIV. No start pulse is issued.
  - Otherwise go to START.
- START:
  - md_ctrl_MULT or md_ctrl_DIV is 1 for exactly this cycle, per the latched kind.
  - stall=1, counter cleared, go to BUSY.
  - md_resultRDY is ignored in START.
- BUSY:
  - stall=1, counter increments each cycle.
  - If md_resultRDY: go to DONE with one of the following:
    - md_exception=1: wb_rd=RSTATUS_REG, wb_data=EXC_MUL or EXC_DIV.
    - md_exception=0: wb_rd=latched rd, wb_data=md_result.
  - Else if counter==TIMEOUT-1: go to DONE with wb_rd=RSTATUS_REG, wb_data=EXC_TMO.
- DONE:
  - wb_valid=1. wb_rd and wb_data are held stable.
  - While wb_grant=0: stall=1.
  - On wb_grant=1: stall=0 and xm_kill=1 in that same cycle, then go to IDLE. The mul/div leaves D/X as a nop.
- Back-to-back mul/div: the next instruction is detected in IDLE on the cycle after the grant, so there is no lost or double issue.
- wb_valid, md_ctrl_*, wb_rd and wb_data are registered outputs. stall and xm_kill are combinational from state and inputs.
- An rd of 0 is passed through unchanged; the register file discards writes to r0.
- Minimum latency from detect to wb_valid, when md_resultRDY arrives in the first BUSY cycle: 3 cycles.

Decomposition:
- Shared package: opcode RTYPE=0, ALU op codes MUL=6 and DIV=7, exception codes, RSTATUS index, state encoding.
- One sub-module md_decode (combinational): DXIR -> is_md, is_div, rd. Reused by hazard logic.

Test Plan:
- mul with opA=7, opB=6, rd=3; RDY after 5 BUSY cycles with result 42; grant immediate -> one MULT pulse; stall high throughout; wb_valid with rd=3, data=42; xm_kill exactly in the grant cycle.
- div with opB=0 -> no DIV pulse; DONE on the next cycle with rd=30, data=5.
- mul whose RDY arrives with md_exception=1 -> rd=30, data=4. Repeat for div -> data=5.
- RDY never asserted -> after 40 BUSY cycles: rd=30, data=6, state returns to IDLE after grant.
- wb_grant withheld 3 cycles in DONE -> wb_valid and data stable, stall=1; two back-to-back muls each issue exactly one MULT pulse.
- reset pulled low during BUSY, then RDY arrives after release -> all outputs 0, no wb_valid.
